// File: rtl/n_bit_grant_decoder_pkg.sv
// Shared types and helpers for the grant decoder.
package n_bit_grant_decoder_pkg;

    // Grant sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Bits needed to index n items; at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/index_onehot_decoder.sv
// Combinational index-to-one-hot decoder with an in-range flag.
module index_onehot_decoder
    import n_bit_grant_decoder_pkg::*;
#(
    parameter int unsigned W_DATA = 32
) (
    input  logic [idx_width(W_DATA)-1:0] idx,
    output logic [W_DATA-1:0]            onehot_c,
    output logic                         valid_c
);

    // Out-of-range indices decode to all zeros with valid_c low.
    always_comb begin
        onehot_c = '0;
        valid_c  = (32'(idx) < W_DATA);
        for (int i = 0; i < W_DATA; i++) begin
            onehot_c[i] = (32'(idx) == 32'(i));
        end
    end

endmodule

// File: rtl/n_bit_grant_decoder.sv
// Grant decoder: turns an accepted winner index into a registered one-hot
// grant held until release. Optional watchdog revoke via GRANT_TIMEOUT_EN.
module n_bit_grant_decoder
    import n_bit_grant_decoder_pkg::*;
#(
    parameter int unsigned W_DATA   = 32,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [idx_width(W_DATA)-1:0] idx_in,
    input  logic                         idx_valid,
    output logic                         idx_ready,
    input  logic [W_DATA-1:0]            release_in,
    output logic [W_DATA-1:0]            grant_onehot,
    output logic                         grant_active,
    output logic                         idx_err,
    output logic                         timeout
);

    localparam int unsigned CNT_W = idx_width(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W_DATA-1:0]  grant_d;
    logic               err_d;
    logic [W_DATA-1:0]  dec_onehot;
    logic               dec_valid;
`ifdef GRANT_TIMEOUT_EN
    logic               timeout_d;
`endif

    index_onehot_decoder #(
        .W_DATA   (W_DATA)
    ) u_dec (
        .idx      (idx_in),
        .onehot_c (dec_onehot),
        .valid_c  (dec_valid)
    );

    assign idx_ready = (state_q == IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_onehot;
        err_d   = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (idx_valid) begin
                    if (dec_valid) begin
                        state_d = GRANT;
                        grant_d = dec_onehot;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Only the granted line's release bit matters.
                if (|(release_in & grant_onehot)) begin
                    grant_d = '0;
                    state_d = DRAIN;
                end
`ifdef GRANT_TIMEOUT_EN
                else if (cnt_q == CNT_MAX) begin
                    grant_d   = '0;
                    state_d   = DRAIN;
                    timeout_d = 1'b1;
                end
`endif
            end
            DRAIN: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs and hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            grant_onehot <= '0;
            grant_active <= 1'b0;
            idx_err      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            grant_onehot <= grant_d;
            grant_active <= |grant_d;
            idx_err      <= err_d;
        end
    end

`ifdef GRANT_TIMEOUT_EN
    // Watchdog revoke pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= timeout_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
